// File: rtl/hp_bench_pkg.sv
// Shared types and AXI constants for the HP-port bandwidth bench sequencer.
package hp_bench_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned BURST_BEATS    = 256;
  localparam int unsigned BURST_BYTES    = 4096;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [2:0]  AXI_SIZE_16B   = 3'd4;
  localparam logic [7:0]  BURST_LEN      = 8'(BURST_BEATS - 1);

  // Checksum contribution of one 128-bit beat: four 32-bit lanes, wrapping.
  function automatic logic [31:0] lane_sum(input logic [127:0] d);
    return d[31:0] + d[63:32] + d[95:64] + d[127:96];
  endfunction

endpackage

// File: rtl/hp_bench_value_gen.sv
// Write-data pattern generator: four independent 32-bit lanes, each stepping by its stride.
module hp_bench_value_gen (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic         advance,
  input  logic [127:0] value,
  input  logic [127:0] stride,
  output logic [127:0] data
);

  logic [127:0] data_q, data_d;

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = value;
    end else if (advance) begin
      for (int l = 0; l < 4; l++) begin
        data_d[l*32 +: 32] = data_q[l*32 +: 32] + stride[l*32 +: 32];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) data_q <= '0;
    else       data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/hp_bench_sequencer.sv
// Issues 4 KB INCR bursts over an address range on an AXI HP port, generating write data
// or checksumming read data, with a bounded number of bursts in flight.
module hp_bench_sequencer
  import hp_bench_pkg::*;
#(
  parameter int HP_ADDR_WIDTH   = 48,
  parameter int HP_DATA_WIDTH   = 128,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic                     clear,
  input  logic                     mode,
  input  logic [63:0]              start_addr,
  input  logic [63:0]              end_addr,
  input  logic [HP_DATA_WIDTH-1:0] start_value,
  input  logic [HP_DATA_WIDTH-1:0] value_stride,
  output logic [1:0]               state,
  output logic [31:0]              checksum,
  output logic                     error,
  output logic [31:0]              bursts_done,
  output logic [HP_ADDR_WIDTH-1:0] hp_awaddr,
  output logic [7:0]               hp_awlen,
  output logic [2:0]               hp_awsize,
  output logic [1:0]               hp_awburst,
  output logic                     hp_awvalid,
  input  logic                     hp_awready,
  output logic [HP_DATA_WIDTH-1:0] hp_wdata,
  output logic [15:0]              hp_wstrb,
  output logic                     hp_wlast,
  output logic                     hp_wvalid,
  input  logic                     hp_wready,
  input  logic [1:0]               hp_bresp,
  input  logic                     hp_bvalid,
  output logic                     hp_bready,
  output logic [HP_ADDR_WIDTH-1:0] hp_araddr,
  output logic [7:0]               hp_arlen,
  output logic [2:0]               hp_arsize,
  output logic [1:0]               hp_arburst,
  output logic                     hp_arvalid,
  input  logic                     hp_arready,
  input  logic [HP_DATA_WIDTH-1:0] hp_rdata,
  input  logic [1:0]               hp_rresp,
  input  logic                     hp_rlast,
  input  logic                     hp_rvalid,
  output logic                     hp_rready
);

  localparam int PAGE_BITS = $clog2(BURST_BYTES);
  localparam int PW        = HP_ADDR_WIDTH - PAGE_BITS;

  state_e                   state_q, state_d;
  logic                     mode_q, mode_d;
  logic [PW-1:0]            page_q, page_d, total_q, total_d;
  logic [PW-1:0]            issued_q, issued_d, w_burst_q, w_burst_d;
  logic [7:0]               w_beat_q, w_beat_d, r_beat_q, r_beat_d;
  logic [3:0]               outstanding_q, outstanding_d;
  logic                     awvalid_q, awvalid_d, arvalid_q, arvalid_d;
  logic [HP_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]              checksum_q, checksum_d, bursts_done_q, bursts_done_d;
  logic                     error_q, error_d;

  logic [PW-1:0] s_page, e_page;
  logic          launch, active, aw_fire, ar_fire, w_fire, b_fire, r_fire;
  logic          burst_end, can_issue, unused_addr_bits;

  // Only whole 4 KB pages inside the HP address space matter.
  assign s_page           = start_addr[HP_ADDR_WIDTH-1:PAGE_BITS];
  assign e_page           = end_addr[HP_ADDR_WIDTH-1:PAGE_BITS];
  assign unused_addr_bits = ^{start_addr[63:HP_ADDR_WIDTH], start_addr[PAGE_BITS-1:0],
                              end_addr[63:HP_ADDR_WIDTH], end_addr[PAGE_BITS-1:0]};

  assign launch    = start && (state_q == ST_IDLE);
  assign active    = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign aw_fire   = awvalid_q && hp_awready;
  assign ar_fire   = arvalid_q && hp_arready;
  assign w_fire    = hp_wvalid && hp_wready;
  assign b_fire    = hp_bvalid && hp_bready;
  assign r_fire    = hp_rvalid && hp_rready;
  assign burst_end = b_fire || (r_fire && hp_rlast);
  // A new address is presented only after the previous one has handshaken and the count settled.
  assign can_issue = (state_q == ST_ISSUE) && (issued_q != total_q) && !awvalid_q && !arvalid_q &&
                     (outstanding_q < 4'(MAX_OUTSTANDING));

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    page_d        = page_q;
    total_d       = total_q;
    issued_d      = issued_q;
    w_burst_d     = w_burst_q;
    w_beat_d      = w_beat_q;
    r_beat_d      = r_beat_q;
    outstanding_d = outstanding_q;
    awvalid_d     = awvalid_q;
    arvalid_d     = arvalid_q;
    addr_d        = addr_q;
    checksum_d    = checksum_q;
    bursts_done_d = bursts_done_q;
    error_d       = error_q;

    if (aw_fire || ar_fire) begin
      awvalid_d = 1'b0;
      arvalid_d = 1'b0;
      issued_d  = issued_q + PW'(1);
    end else if (can_issue) begin
      addr_d    = {page_q + issued_q, {PAGE_BITS{1'b0}}};
      awvalid_d = !mode_q;
      arvalid_d = mode_q;
    end

    if (w_fire) begin
      w_beat_d = w_beat_q + 8'd1;
      if (w_beat_q == BURST_LEN) w_burst_d = w_burst_q + PW'(1);
    end

    if (r_fire) begin
      r_beat_d   = hp_rlast ? 8'd0 : r_beat_q + 8'd1;
      checksum_d = checksum_q + lane_sum(hp_rdata);
      if ((hp_rresp != 2'b00) || (hp_rlast != (r_beat_q == BURST_LEN))) error_d = 1'b1;
    end
    if (b_fire && (hp_bresp != 2'b00)) error_d = 1'b1;

    if ((aw_fire || ar_fire) && !burst_end)                           outstanding_d = outstanding_q + 4'd1;
    else if (!(aw_fire || ar_fire) && burst_end && outstanding_q != 0) outstanding_d = outstanding_q - 4'd1;
    if (burst_end) bursts_done_d = bursts_done_q + 32'd1;

    case (state_q)
      ST_IDLE: if (start) begin
        mode_d        = mode;
        page_d        = s_page;
        total_d       = (e_page > s_page) ? e_page - s_page : '0;
        issued_d      = '0;
        w_burst_d     = '0;
        w_beat_d      = '0;
        r_beat_d      = '0;
        outstanding_d = '0;
        checksum_d    = '0;
        bursts_done_d = '0;
        error_d       = 1'b0;
        state_d       = (e_page > s_page) ? ST_ISSUE : ST_DONE;
      end
      ST_ISSUE: if ((issued_q == total_q) && (mode_q || (w_burst_q == total_q))) state_d = ST_DRAIN;
      ST_DRAIN: if (outstanding_q == 4'd0) state_d = ST_DONE;
      ST_DONE:  if (clear) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      mode_q        <= 1'b0;
      page_q        <= '0;
      total_q       <= '0;
      issued_q      <= '0;
      w_burst_q     <= '0;
      w_beat_q      <= '0;
      r_beat_q      <= '0;
      outstanding_q <= '0;
      awvalid_q     <= 1'b0;
      arvalid_q     <= 1'b0;
      addr_q        <= '0;
      checksum_q    <= '0;
      bursts_done_q <= '0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      page_q        <= page_d;
      total_q       <= total_d;
      issued_q      <= issued_d;
      w_burst_q     <= w_burst_d;
      w_beat_q      <= w_beat_d;
      r_beat_q      <= r_beat_d;
      outstanding_q <= outstanding_d;
      awvalid_q     <= awvalid_d;
      arvalid_q     <= arvalid_d;
      addr_q        <= addr_d;
      checksum_q    <= checksum_d;
      bursts_done_q <= bursts_done_d;
      error_q       <= error_d;
    end
  end

  hp_bench_value_gen u_value_gen (
    .clk     (clk),
    .rstn    (rstn),
    .load    (launch),
    .advance (w_fire),
    .value   (start_value),
    .stride  (value_stride),
    .data    (hp_wdata)
  );

  assign state       = state_q;
  assign checksum    = checksum_q;
  assign error       = error_q;
  assign bursts_done = bursts_done_q;

  assign hp_awaddr  = addr_q;
  assign hp_awlen   = BURST_LEN;
  assign hp_awsize  = AXI_SIZE_16B;
  assign hp_awburst = AXI_BURST_INCR;
  assign hp_awvalid = awvalid_q;
  assign hp_araddr  = addr_q;
  assign hp_arlen   = BURST_LEN;
  assign hp_arsize  = AXI_SIZE_16B;
  assign hp_arburst = AXI_BURST_INCR;
  assign hp_arvalid = arvalid_q;

  // W for burst k is offered only once AW k has handshaken.
  assign hp_wvalid = (state_q == ST_ISSUE) && !mode_q && (w_burst_q != issued_q);
  assign hp_wlast  = hp_wvalid && (w_beat_q == BURST_LEN);
  assign hp_wstrb  = '1;
  assign hp_bready = active;
  assign hp_rready = active;

endmodule

// File: doc/hp_bench_sequencer.md
HP_BENCH_SEQUENCER -- requirements
Module: hp_bench_sequencer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- HP_ADDR_WIDTH, 48, HP address width.
- HP_DATA_WIDTH, 128, HP data width; fixed at 128 and not varied.
- MAX_OUTSTANDING, 4, maximum bursts issued but not yet completed (1..15).

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  in  1  sole clock.
- rstn  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle pulse; launches a run.
- clear  in  1  one-cycle pulse; returns DONE to IDLE.
- mode  in  1  0 = write bench, 1 = read bench.
- start_addr / end_addr  in  64 each  byte range [start_addr, end_addr).
- start_value / value_stride  in  128 each  first write beat / per-beat lane increment.
- state  out  2  IDLE=0, ISSUE=1, DRAIN=2, DONE=3.
- checksum  out  32  read-bench checksum.
- error  out  1  sticky response or protocol error.
- bursts_done  out  32  completed bursts in the current run.
- hp_aw*  out  awaddr 48, awlen 8, awsize 3, awburst 2, awvalid 1; hp_awready in 1.
- hp_w*  out  wdata 128, wstrb 16, wlast 1, wvalid 1; hp_wready in 1.
- hp_b*  in  bresp 2, bvalid 1; hp_bready out 1.
- hp_ar*  out  araddr 48, arlen 8, arsize 3, arburst 2, arvalid 1; hp_arready in 1.
- hp_r*  in  rdata 128, rresp 2, rlast 1, rvalid 1; hp_rready out 1.

Function
REQ-003 Every burst is 4 KB: len=255, size=4 (16 B), burst=INCR (01); wstrb = all ones.
REQ-004 Address handling: bits [11:0] of start_addr and end_addr are ignored; the range is truncated to HP_ADDR_WIDTH; burst k uses address start + 4096*k.
REQ-005 On start in IDLE: latch all config inputs; clear checksum, error and bursts_done; go to ISSUE. Start outside IDLE is ignored.
REQ-006 Empty range: if end <= start (after masking), the run goes IDLE -> DONE in one cycle with no AXI traffic.
REQ-007 ISSUE, mode 0: assert awvalid while outstanding < MAX_OUTSTANDING and bursts remain; awaddr and awvalid stay stable until awready.
REQ-008 W data for burst k is driven only after AW k has handshaken; beats are in order; wlast is asserted on beat 255 only.
REQ-009 Write data: beat n carries start_value + n*value_stride per 32-bit lane, each lane mod 2^32 with no carry between lanes; the beat counter n runs across the whole run.
REQ-010 ISSUE, mode 1: assert arvalid under the same outstanding rule as AW; hp_rready = 1 in ISSUE and DRAIN.
REQ-011 Read checksum: on every accepted R beat, checksum += sum of the four 32-bit lanes, mod 2^32.
REQ-012 Outstanding count: +1 on AW/AR handshake, -1 on the last B (or last R); both in the same cycle leaves it unchanged.
REQ-013 hp_bready = 1 in ISSUE and DRAIN; each B, or each R beat with rlast, increments bursts_done.
REQ-014 error is set and held until the next start on any of: bresp != 0; rresp != 0; rlast on a beat other than 255; beat 255 without rlast.
REQ-015 ISSUE -> DRAIN when the last AW/AR has handshaken and, in write mode, its final W beat has been accepted.
REQ-016 DRAIN -> DONE when outstanding = 0; DONE -> IDLE on clear; clear in any other state is ignored.
REQ-017 The registers are not readable over AXI. checksum and bursts_done hold their values in DONE and IDLE until the next start.

Reset
REQ-018 When rstn is low, all of the following are 0 asynchronously: state (IDLE), all hp_*valid, hp_bready, hp_rready, hp_wlast, error, checksum, bursts_done, outstanding and the beat counters.
REQ-019 Reset mid-run abandons all in-flight bursts; after reset release the block stays in IDLE until start.

Structure
REQ-020 Package hp_bench_pkg holds the state enum plus the constants BURST_BEATS=256, BURST_BYTES=4096, AXI_BURST_INCR=2'b01 and AXI_SIZE_16B=3'd4.
REQ-021 The lane-wise stride adder (REQ-009) is the sub-module hp_bench_value_gen, with inputs load, advance, value and stride, and one registered 128-bit output.

Verification
REQ-022 Write, 2 bursts: start=0x1000, end=0x3000, value=0, stride=1/lane; always-ready slave -> awaddr 0x1000 then 0x2000, last beat lanes = 511, bursts_done=2, DONE.
REQ-023 Read, 1 burst: slave returns each lane = 1 -> checksum = 1024, error = 0.
REQ-024 Backpressure, 8 bursts with B responses delayed 50 cycles -> at most MAX_OUTSTANDING=4 outstanding, exactly 8 AW handshakes.
REQ-025 Error: second burst gets bresp=2 -> error=1, run still reaches DONE, bursts_done=2.
REQ-026 Boundaries: end == start -> DONE with no valid ever asserted; rlast on beat 100 -> error=1.
REQ-027 Reset: rstn low during beat 10 of burst 0 -> all valids 0 with no clock edge; after release, state=IDLE and a fresh start runs correctly.
